// File: rtl/id_operand_stage_pkg.sv
// id_operand_stage shared types and helpers.
// Stage-hit compare and register-zero constant.
package id_operand_stage_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic logic stage_hit(
    input logic       le,
    input logic [4:0] rd,
    input logic [4:0] src
  );
    return le && (rd == src) && (src != REG_ZERO);
  endfunction

endpackage

// File: rtl/operand_forward_mux.sv
// Operand forward mux: EX > MEM > WB > regfile.
// Source R0 always resolves to zero.
module operand_forward_mux
  import id_operand_stage_pkg::*;
(
  input  logic [4:0]  i_src,
  input  logic [31:0] i_rf_val,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_le,
  input  logic        i_ex_load,
  input  logic [31:0] i_ex_val,
  input  logic [4:0]  i_mem_rd,
  input  logic        i_mem_le,
  input  logic [31:0] i_mem_val,
  input  logic [4:0]  i_wb_rd,
  input  logic        i_wb_le,
  input  logic [31:0] i_wb_val,
  output logic [31:0] o_val
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = stage_hit(i_ex_le, i_ex_rd, i_src)
                   && !i_ex_load;
  assign w_mem_hit = stage_hit(i_mem_le, i_mem_rd, i_src);
  assign w_wb_hit  = stage_hit(i_wb_le, i_wb_rd, i_src);

  // Youngest producer wins; a pending load in EX is skipped.
  always_comb begin
    o_val = i_rf_val;
    if (i_src == REG_ZERO)
      o_val = 32'h0;
    else if (w_ex_hit)
      o_val = i_ex_val;
    else if (w_mem_hit)
      o_val = i_mem_val;
    else if (w_wb_hit)
      o_val = i_wb_val;
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: forwarding, load-use stall,
// and the ID/EX pipeline register.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int CTRL_W = 16
) (
  input  logic              CLK,
  input  logic              R,
  input  logic              ID_VALID,
  input  logic [4:0]        RA,
  input  logic [4:0]        RB,
  input  logic              USE_A,
  input  logic              USE_B,
  input  logic [31:0]       PA,
  input  logic [31:0]       PB,
  input  logic [4:0]        ID_RD,
  input  logic              ID_RF_LE,
  input  logic              ID_LOAD,
  input  logic [CTRL_W-1:0] ID_CTRL,
  input  logic [4:0]        EX_RD,
  input  logic [4:0]        MEM_RD,
  input  logic [4:0]        WB_RD,
  input  logic              EX_RF_LE,
  input  logic              MEM_RF_LE,
  input  logic              WB_RF_LE,
  input  logic              EX_LOAD,
  input  logic [31:0]       EX_VAL,
  input  logic [31:0]       MEM_VAL,
  input  logic [31:0]       WB_VAL,
  input  logic              FLUSH,
  output logic              STALL,
  output logic [31:0]       OPA,
  output logic [31:0]       OPB,
  output logic [4:0]        EX_DEST,
  output logic              EX_RF_LE_O,
  output logic              EX_LOAD_O,
  output logic              EX_VALID,
  output logic [CTRL_W-1:0] EX_CTRL
);

  logic [31:0] w_opa;
  logic [31:0] w_opb;
  logic        w_use_hit;
  logic        w_stall;

  operand_forward_mux u_fwd_a (
    .i_src     (RA),
    .i_rf_val  (PA),
    .i_ex_rd   (EX_RD),
    .i_ex_le   (EX_RF_LE),
    .i_ex_load (EX_LOAD),
    .i_ex_val  (EX_VAL),
    .i_mem_rd  (MEM_RD),
    .i_mem_le  (MEM_RF_LE),
    .i_mem_val (MEM_VAL),
    .i_wb_rd   (WB_RD),
    .i_wb_le   (WB_RF_LE),
    .i_wb_val  (WB_VAL),
    .o_val     (w_opa)
  );

  operand_forward_mux u_fwd_b (
    .i_src     (RB),
    .i_rf_val  (PB),
    .i_ex_rd   (EX_RD),
    .i_ex_le   (EX_RF_LE),
    .i_ex_load (EX_LOAD),
    .i_ex_val  (EX_VAL),
    .i_mem_rd  (MEM_RD),
    .i_mem_le  (MEM_RF_LE),
    .i_mem_val (MEM_VAL),
    .i_wb_rd   (WB_RD),
    .i_wb_le   (WB_RF_LE),
    .i_wb_val  (WB_VAL),
    .o_val     (w_opb)
  );

  // stage_hit excludes R0, so EX_RD!=0 is implied.
  assign w_use_hit =
      (USE_A && stage_hit(EX_RF_LE, EX_RD, RA))
    || (USE_B && stage_hit(EX_RF_LE, EX_RD, RB));

  assign w_stall = ID_VALID && !FLUSH
                && EX_LOAD && w_use_hit;

  assign STALL = w_stall;

  // Reset, flush and stall all leave an all-zero bubble.
  always_ff @(posedge CLK) begin
    if (R || FLUSH || w_stall) begin
      OPA        <= 32'h0;
      OPB        <= 32'h0;
      EX_DEST    <= REG_ZERO;
      EX_RF_LE_O <= 1'b0;
      EX_LOAD_O  <= 1'b0;
      EX_VALID   <= 1'b0;
      EX_CTRL    <= '0;
    end else begin
      OPA        <= w_opa;
      OPB        <= w_opb;
      EX_DEST    <= ID_RD;
      EX_RF_LE_O <= ID_RF_LE && ID_VALID;
      EX_LOAD_O  <= ID_LOAD && ID_VALID;
      EX_VALID   <= ID_VALID;
      EX_CTRL    <= ID_CTRL;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage.
// Hand-computed expectations per vector.
module tb_id_operand_stage;

  logic        CLK = 1'b0;
  logic        R;
  logic        ID_VALID;
  logic [4:0]  RA, RB;
  logic        USE_A, USE_B;
  logic [31:0] PA, PB;
  logic [4:0]  ID_RD;
  logic        ID_RF_LE, ID_LOAD;
  logic [15:0] ID_CTRL;
  logic [4:0]  EX_RD, MEM_RD, WB_RD;
  logic        EX_RF_LE, MEM_RF_LE, WB_RF_LE;
  logic        EX_LOAD;
  logic [31:0] EX_VAL, MEM_VAL, WB_VAL;
  logic        FLUSH;
  logic        STALL;
  logic [31:0] OPA, OPB;
  logic [4:0]  EX_DEST;
  logic        EX_RF_LE_O, EX_LOAD_O, EX_VALID;
  logic [15:0] EX_CTRL;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  id_operand_stage #(.CTRL_W(16)) dut (
    .CLK(CLK), .R(R), .ID_VALID(ID_VALID),
    .RA(RA), .RB(RB),
    .USE_A(USE_A), .USE_B(USE_B),
    .PA(PA), .PB(PB),
    .ID_RD(ID_RD), .ID_RF_LE(ID_RF_LE),
    .ID_LOAD(ID_LOAD), .ID_CTRL(ID_CTRL),
    .EX_RD(EX_RD), .MEM_RD(MEM_RD), .WB_RD(WB_RD),
    .EX_RF_LE(EX_RF_LE), .MEM_RF_LE(MEM_RF_LE),
    .WB_RF_LE(WB_RF_LE), .EX_LOAD(EX_LOAD),
    .EX_VAL(EX_VAL), .MEM_VAL(MEM_VAL),
    .WB_VAL(WB_VAL), .FLUSH(FLUSH),
    .STALL(STALL), .OPA(OPA), .OPB(OPB),
    .EX_DEST(EX_DEST), .EX_RF_LE_O(EX_RF_LE_O),
    .EX_LOAD_O(EX_LOAD_O), .EX_VALID(EX_VALID),
    .EX_CTRL(EX_CTRL)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    R = 1'b0; ID_VALID = 1'b0;
    RA = 5'd0; RB = 5'd0;
    USE_A = 1'b0; USE_B = 1'b0;
    PA = 32'h0; PB = 32'h0;
    ID_RD = 5'd0; ID_RF_LE = 1'b0;
    ID_LOAD = 1'b0; ID_CTRL = 16'h0;
    EX_RD = 5'd0; MEM_RD = 5'd0; WB_RD = 5'd0;
    EX_RF_LE = 1'b0; MEM_RF_LE = 1'b0;
    WB_RF_LE = 1'b0; EX_LOAD = 1'b0;
    EX_VAL = 32'h0; MEM_VAL = 32'h0;
    WB_VAL = 32'h0; FLUSH = 1'b0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".opa"}, OPA, 32'h0);
    chk({tag, ".opb"}, OPB, 32'h0);
    chk({tag, ".dst"}, {27'h0, EX_DEST}, 32'h0);
    chk({tag, ".le"}, {31'h0, EX_RF_LE_O}, 32'h0);
    chk({tag, ".ld"}, {31'h0, EX_LOAD_O}, 32'h0);
    chk({tag, ".vld"}, {31'h0, EX_VALID}, 32'h0);
    chk({tag, ".ctl"}, {16'h0, EX_CTRL}, 32'h0);
  endtask

  // Valid ID instruction with no hazards.
  task automatic base();
    clr();
    ID_VALID = 1'b1;
    RA = 5'd3; USE_A = 1'b1; PA = 32'h11;
    RB = 5'd4; USE_B = 1'b1; PB = 32'h22;
    ID_RD = 5'd7; ID_RF_LE = 1'b1;
    ID_CTRL = 16'hBEEF;
  endtask

  initial begin
    clr();
    R = 1'b1;
    step();
    chk_zero("rst");

    base();
    ID_LOAD = 1'b1;
    #1;
    chk("t1.stall", {31'h0, STALL}, 32'h0);
    step();
    chk("t1.opa", OPA, 32'h11);
    chk("t1.opb", OPB, 32'h22);
    chk("t1.dst", {27'h0, EX_DEST}, 32'd7);
    chk("t1.le", {31'h0, EX_RF_LE_O}, 32'h1);
    chk("t1.ld", {31'h0, EX_LOAD_O}, 32'h1);
    chk("t1.vld", {31'h0, EX_VALID}, 32'h1);
    chk("t1.ctl", {16'h0, EX_CTRL}, 32'hBEEF);

    base();
    EX_RD = 5'd3; EX_RF_LE = 1'b1; EX_VAL = 32'hAA;
    MEM_RD = 5'd3; MEM_RF_LE = 1'b1; MEM_VAL = 32'hBB;
    WB_RD = 5'd4; WB_RF_LE = 1'b1; WB_VAL = 32'hCC;
    step();
    chk("ex_wins", OPA, 32'hAA);
    chk("wb_fwd", OPB, 32'hCC);
    EX_RF_LE = 1'b0;
    step();
    chk("mem_fwd", OPA, 32'hBB);

    base();
    RA = 5'd0; PA = 32'hFFFFFFFF;
    EX_RD = 5'd0; EX_RF_LE = 1'b1;
    EX_LOAD = 1'b1; EX_VAL = 32'hFFFFFFFF;
    MEM_RD = 5'd0; MEM_RF_LE = 1'b1;
    MEM_VAL = 32'hFFFFFFFF;
    WB_RD = 5'd0; WB_RF_LE = 1'b1;
    WB_VAL = 32'hFFFFFFFF;
    #1;
    chk("r0.stall", {31'h0, STALL}, 32'h0);
    step();
    chk("r0.opa", OPA, 32'h0);
    chk("r0.vld", {31'h0, EX_VALID}, 32'h1);

    base();
    RB = 5'd5;
    EX_RD = 5'd5; EX_RF_LE = 1'b1;
    EX_LOAD = 1'b1; EX_VAL = 32'hDEAD;
    #1;
    chk("lu.stall", {31'h0, STALL}, 32'h1);
    step();
    chk("lu.vld", {31'h0, EX_VALID}, 32'h0);
    chk("lu.le", {31'h0, EX_RF_LE_O}, 32'h0);
    chk("lu.opa", OPA, 32'h0);
    EX_RF_LE = 1'b0; EX_LOAD = 1'b0;
    MEM_RD = 5'd5; MEM_RF_LE = 1'b1;
    MEM_VAL = 32'h77;
    #1;
    chk("lu2.stall", {31'h0, STALL}, 32'h0);
    step();
    chk("lu2.opb", OPB, 32'h77);
    chk("lu2.vld", {31'h0, EX_VALID}, 32'h1);

    base();
    RB = 5'd5; USE_B = 1'b0; PB = 32'h55;
    EX_RD = 5'd5; EX_RF_LE = 1'b1;
    EX_LOAD = 1'b1; EX_VAL = 32'hDEAD;
    #1;
    chk("nouse.stall", {31'h0, STALL}, 32'h0);
    step();
    chk("nouse.opb", OPB, 32'h55);
    chk("nouse.vld", {31'h0, EX_VALID}, 32'h1);

    base();
    RA = 5'd9; USE_A = 1'b1;
    EX_RD = 5'd9; EX_RF_LE = 1'b1;
    EX_LOAD = 1'b1;
    #1;
    chk("lua.stall", {31'h0, STALL}, 32'h1);
    FLUSH = 1'b1;
    #1;
    chk("fl.stall", {31'h0, STALL}, 32'h0);
    step();
    chk_zero("fl");

    base();
    ID_VALID = 1'b0;
    #1;
    chk("iv.stall", {31'h0, STALL}, 32'h0);
    step();
    chk("iv.vld", {31'h0, EX_VALID}, 32'h0);
    chk("iv.le", {31'h0, EX_RF_LE_O}, 32'h0);
    chk("iv.opa", OPA, 32'h11);

    base();
    step();
    chk("pre.vld", {31'h0, EX_VALID}, 32'h1);
    RB = 5'd6;
    EX_RD = 5'd6; EX_RF_LE = 1'b1;
    EX_LOAD = 1'b1;
    R = 1'b1;
    #1;
    chk("rs.stall", {31'h0, STALL}, 32'h1);
    step();
    chk_zero("rs");

    base();
    PA = 32'h1234; PB = 32'h5678;
    step();
    chk("post.opa", OPA, 32'h1234);
    chk("post.opb", OPB, 32'h5678);
    chk("post.vld", {31'h0, EX_VALID}, 32'h1);
    chk("post.dst", {27'h0, EX_DEST}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Decode-side operand stage of the PA-RISC pipeline, directly downstream of the register file's read ports. It resolves operand values by forwarding from the EX, MEM and WB stages with the register file as fallback, detects load-use hazards and requests a one-cycle stall, and captures operands, destination and control into the ID/EX pipeline register. Flush and stall requests insert bubbles into that register.

## Interface
- CTRL_W, 16, width of opaque decoded control bits passed through to EX
- CLK  in  1  rising-edge clock
- R  in  1  synchronous active-high reset
- ID_VALID  in  1  instruction present in ID
- RA, RB  in  5 each  source register numbers driven to the register file read ports
- USE_A, USE_B  in  1 each  instruction actually reads RA / RB
- PA, PB  in  32 each  register file read data for RA / RB
- ID_RD  in  5  destination register of the ID instruction
- ID_RF_LE  in  1  ID instruction writes a register
- ID_LOAD  in  1  ID instruction is a load
- ID_CTRL  in  CTRL_W  decoded control bits
- EX_RD, MEM_RD, WB_RD  in  5 each  destination of the instruction in that stage
- EX_RF_LE, MEM_RF_LE, WB_RF_LE  in  1 each  that stage will write a register; WB_* equals the register file write port (RD/EN)
- EX_LOAD  in  1  EX instruction is a load (value not yet available)
- EX_VAL, MEM_VAL, WB_VAL  in  32 each  result available in that stage; WB_VAL equals PD
- FLUSH  in  1  squash the ID instruction (taken branch)
- STALL  out  1  hold PC and IF/ID this cycle (combinational)
- OPA, OPB  out  32 each  registered resolved operands
- EX_DEST  out  5  registered destination
- EX_RF_LE_O, EX_LOAD_O, EX_VALID  out  1 each  registered write enable, load flag, valid
- EX_CTRL  out  CTRL_W  registered control

## Operation
- Hit in stage S for source X: S_RF_LE=1, S_RD==X, X!=0.
- Operand A resolution priority: EX hit (and not EX_LOAD) -> EX_VAL; else MEM hit -> MEM_VAL; else WB hit -> WB_VAL; else PA. Same for B with RB/PB.
- X==0 always resolves to 32'h0 regardless of any hits.
- WB forwarding covers the register file write-then-read in the same cycle; no bypass inside the register file is relied on.
- Load-use: STALL = ID_VALID & !FLUSH & EX_LOAD & EX_RF_LE & EX_RD!=0 & ((USE_A & EX_RD==RA) | (USE_B & EX_RD==RB)).
- Unused source (USE_x=0) never causes stall; its operand still resolves normally.
- Register update each cycle, priority R > FLUSH > STALL > normal:
  - R: all outputs 0.
  - FLUSH or STALL: bubble: EX_VALID=0, EX_RF_LE_O=0, EX_LOAD_O=0; OPA/OPB/EX_DEST/EX_CTRL loaded with 0.
  - normal: load resolved operands, ID_RD, ID_RF_LE&ID_VALID, ID_LOAD&ID_VALID, ID_CTRL, ID_VALID.
- During STALL the ID instruction remains presented upstream; next cycle the load is in MEM and resolves via MEM_VAL.

## Timing
- STALL and operand resolution combinational, same cycle as inputs.
- Operands/control appear on EX_* one CLK edge after capture; latency 1.
- Reset synchronous: all registered outputs 0 after first edge with R=1; STALL is combinational and follows inputs even during reset.
- R asserted mid-stall: bubble state (all 0) on next edge; no stall memory kept.
- FLUSH coincident with load-use: STALL=0, bubble inserted.
- Back-to-back loads to same register: each stall evaluated independently per cycle; at most one stall cycle per load-use pair.

## Structure
- Shared package: stage-hit compare function and register-zero constant (5'd0), reused by the EX forwarding logic.
- One sub-module natural: operand_forward_mux (one instance per port) implementing the priority select and R0 zeroing; hazard detection and ID/EX register in the top.

## Test plan
- No hazards, RA=3, PA=32'h11: next edge OPA=32'h11, EX_VALID=1.
- EX hit non-load EX_RD=3, EX_VAL=32'hAA, plus MEM hit MEM_RD=3, MEM_VAL=32'hBB: OPA=32'hAA (EX wins); drop EX hit: OPA=32'hBB.
- RA=0 with EX/MEM/WB all targeting R0 with 32'hFFFFFFFF: OPA=0, no STALL.
- EX_LOAD, EX_RD=5, RB=5, USE_B=1: STALL=1, next edge EX_VALID=0, EX_RF_LE_O=0; next cycle MEM_RD=5, MEM_VAL=32'h77: STALL=0, OPB=32'h77. Repeat with USE_B=0: no STALL.
- FLUSH=1 with same load-use: STALL=0, bubble captured.
- R=1 after valid capture: next edge all outputs 0; first cycle after R released captures normally.
